// File: rtl/bcd_countdown_pkg.sv
// Shared types and constants for the packed-BCD countdown timer.
package bcd_countdown_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } cd_state_e;

   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_ZERO = 4'd0;

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the decrement chain: subtracts the incoming borrow, wraps 0 -> 9.
module bcd_digit_down
   import bcd_countdown_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       borrow_in,
   output logic [3:0] next_digit,
   output logic       borrow_out
);

   // Decrement this digit only when a borrow arrives from below
   always_comb begin
      next_digit = digit;
      borrow_out = 1'b0;
      if (borrow_in) begin
         if (digit == BCD_ZERO) begin
            next_digit = BCD_MAX;
            borrow_out = 1'b1;
         end else begin
            next_digit = digit - 4'd1;
         end
      end else begin
         next_digit = digit;
      end
   end

endmodule

// File: rtl/bcd_countdown.sv
// Loadable packed-BCD countdown timer with IDLE/RUN/PAUSED control,
// terminal done pulse and a sticky flag for loads containing non-BCD digits.
module bcd_countdown
   import bcd_countdown_pkg::*;
#(
   parameter int NUM_DIGITS = 2
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   load_val,
   input  logic                      start,
   input  logic                      pause,
   input  logic                      tick,
   output logic [4*NUM_DIGITS-1:0]   count,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   localparam int W = 4 * NUM_DIGITS;
   localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

   cd_state_e           state_r;
   logic [W-1:0]        count_r;
   logic                done_r;
   logic                err_r;

   logic [W-1:0]        dec_s;
   logic [NUM_DIGITS:0] borrow_s;
   logic                load_ok_s;
   logic                is_zero_s;
   logic                is_one_s;

   // The least significant digit always receives the decrement borrow
   assign borrow_s[0] = 1'b1;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit_down u_digit (
         .digit      (count_r[4*g +: 4]),
         .borrow_in  (borrow_s[g]),
         .next_digit (dec_s[4*g +: 4]),
         .borrow_out (borrow_s[g+1])
      );
   end

   // A load is accepted only if every nibble is a legal decimal digit
   always_comb begin
      load_ok_s = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (load_val[4*i +: 4] > BCD_MAX) begin
            load_ok_s = 1'b0;
         end else begin
            load_ok_s = load_ok_s;
         end
      end
   end

   assign is_zero_s = (count_r == {W{1'b0}});
   assign is_one_s  = (count_r == CNT_ONE);

   // Controller and counter; a final borrow out of the chain means the
   // counter is already at zero, so the decrement is suppressed there
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         count_r <= {W{1'b0}};
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (load) begin
            state_r <= IDLE;
            if (load_ok_s) begin
               count_r <= load_val;
               err_r   <= 1'b0;
            end else begin
               err_r   <= 1'b1;
            end
         end else begin
            case (state_r)
               IDLE: begin
                  if (start && !err_r) begin
                     if (is_zero_s) begin
                        done_r  <= 1'b1;
                     end else begin
                        state_r <= RUN;
                     end
                  end
               end
               RUN: begin
                  if (pause) begin
                     state_r <= PAUSED;
                  end else if (tick && !borrow_s[NUM_DIGITS]) begin
                     count_r <= dec_s;
                     if (is_one_s) begin
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                     end
                  end
               end
               PAUSED: begin
                  if (!pause && start) begin
                     state_r <= RUN;
                  end
               end
               default: begin
                  state_r <= IDLE;
               end
            endcase
         end
      end
   end

   assign count = count_r;
   assign done  = done_r;
   assign err   = err_r;
   assign busy  = (state_r != IDLE);

endmodule

// File: tb/tb_bcd_countdown.sv
// Self-checking bench for bcd_countdown: directed scenarios plus random traffic
// checked each cycle against a decimal-integer reference model.
module tb_bcd_countdown;

   localparam int ND = 2;
   localparam int W  = 4 * ND;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          load = 1'b0;
   logic [W-1:0]  load_val = '0;
   logic          start = 1'b0;
   logic          pause = 1'b0;
   logic          tick = 1'b0;
   logic [W-1:0]  count;
   logic          busy;
   logic          done;
   logic          err;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: counter held as a plain integer plus mode flags
   int m_val = 0;
   bit m_run = 1'b0;
   bit m_paused = 1'b0;
   bit m_done = 1'b0;
   bit m_err = 1'b0;

   bcd_countdown #(.NUM_DIGITS(ND)) dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .pause    (pause),
      .tick     (tick),
      .count    (count),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] int2bcd(input int v);
      logic [W-1:0] r = '0;
      int p = 1;
      for (int i = 0; i < ND; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic bit bcd_ok(input logic [W-1:0] b);
      for (int i = 0; i < ND; i++)
         if (int'(b[4*i +: 4]) > 9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int bcd2int(input logic [W-1:0] b);
      int v = 0;
      int p = 1;
      for (int i = 0; i < ND; i++) begin
         v = v + int'(b[4*i +: 4]) * p;
         p = p * 10;
      end
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit l, input logic [W-1:0] lv,
                             input bit s, input bit p, input bit t);
      m_done = 1'b0;
      if (r) begin
         m_val = 0; m_run = 1'b0; m_paused = 1'b0; m_err = 1'b0;
      end else if (l) begin
         m_run = 1'b0; m_paused = 1'b0;
         if (bcd_ok(lv)) begin
            m_val = bcd2int(lv); m_err = 1'b0;
         end else begin
            m_err = 1'b1;
         end
      end else if (m_paused) begin
         if (!p && s) begin
            m_paused = 1'b0; m_run = 1'b1;
         end
      end else if (m_run) begin
         if (p) begin
            m_run = 1'b0; m_paused = 1'b1;
         end else if (t && m_val > 0) begin
            m_val = m_val - 1;
            if (m_val == 0) begin
               m_run = 1'b0; m_done = 1'b1;
            end
         end
      end else if (s && !m_err) begin
         if (m_val == 0) m_done = 1'b1;
         else m_run = 1'b1;
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, compare on the falling edge
   task automatic cyc(input bit r, input bit l, input logic [W-1:0] lv,
                      input bit s, input bit p, input bit t);
      reset = r; load = l; load_val = lv; start = s; pause = p; tick = t;
      @(posedge clk);
      model_step(r, l, lv, s, p, t);
      @(negedge clk);
      chk("count", 32'(count), 32'(int2bcd(m_val)));
      chk("busy",  32'(busy),  32'(m_run || m_paused));
      chk("done",  32'(done),  32'(m_done));
      chk("err",   32'(err),   32'(m_err));
   endtask

   task automatic idle_cyc();
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_load(input logic [W-1:0] v);
      cyc(1'b0, 1'b1, v, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_start();
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic do_tick();
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      int done_seen;
      bit r, l, s, p, t;
      logic [W-1:0] lv;

      cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_busy",  32'(busy),  32'h0);

      // Full countdown from 25
      do_load(8'h25);
      do_start();
      done_seen = 0;
      for (int k = 1; k <= 25; k++) begin
         do_tick();
         chk("seq_count", 32'(count), 32'(int2bcd(25 - k)));
         if (done) done_seen++;
      end
      chk("seq_done_once", 32'(done_seen), 32'd1);
      chk("seq_busy_end", 32'(busy), 32'h0);
      idle_cyc();
      chk("seq_done_low", 32'(done), 32'h0);

      // Borrow across digits and start at zero
      do_load(8'h10); do_start(); do_tick();
      chk("borrow_09", 32'(count), 32'h09);
      do_load(8'h00); do_start();
      chk("zero_done", 32'(done), 32'h1);
      chk("zero_busy", 32'(busy), 32'h0);
      idle_cyc();

      // Invalid load keeps count, blocks start, cleared by valid load
      do_load(8'h42); do_load(8'h3A);
      chk("inv_err", 32'(err), 32'h1);
      chk("inv_count", 32'(count), 32'h42);
      do_start();
      chk("inv_start_ignored", 32'(busy), 32'h0);
      do_load(8'h05);
      chk("inv_cleared", 32'(err), 32'h0);

      // Pause with simultaneous tick, hold, resume
      do_load(8'h12); do_start();
      repeat (3) do_tick();
      chk("pause_pre", 32'(count), 32'h09);
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
      repeat (4) do_tick();
      chk("pause_hold", 32'(count), 32'h09);
      chk("pause_busy", 32'(busy), 32'h1);
      do_start(); do_tick();
      chk("resume", 32'(count), 32'h08);

      // Reset in RUN, then load in RUN
      do_load(8'h10); do_start();
      repeat (3) do_tick();
      chk("ovr_pre", 32'(count), 32'h07);
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("ovr_rst_count", 32'(count), 32'h0);
      chk("ovr_rst_done", 32'(done), 32'h0);
      do_load(8'h20); do_start(); do_tick();
      cyc(1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
      chk("ovr_load_count", 32'(count), 32'h33);
      chk("ovr_load_busy", 32'(busy), 32'h0);
      chk("ovr_load_done", 32'(done), 32'h0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         r = ($urandom_range(0, 299) == 0);
         l = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 3) == 0) lv = W'($urandom);
         else lv = int2bcd(int'($urandom_range(0, 30)));
         s = ($urandom_range(0, 7) == 0);
         p = ($urandom_range(0, 11) == 0);
         t = ($urandom_range(0, 2) != 0);
         cyc(r, l, lv, s, p, t);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bcd_countdown.md
BCD_COUNTDOWN -- requirements
Module: bcd_countdown

Interface
REQ-001 Parameter SHALL be: NUM_DIGITS, default 2, number of BCD digits; counter width W = 4*NUM_DIGITS.
REQ-002 Port SHALL be: clk  input  1  clock; all state changes on rising edge.
REQ-003 Port SHALL be: reset  input  1  reset, synchronous, active-high.
REQ-004 Port SHALL be: load  input  1  load load_val into counter.
REQ-005 Port SHALL be: load_val  input  W  packed BCD load value, digit 0 in bits [3:0].
REQ-006 Port SHALL be: start  input  1  begin or resume countdown.
REQ-007 Port SHALL be: pause  input  1  suspend countdown.
REQ-008 Port SHALL be: tick  input  1  single-cycle decrement strobe.
REQ-009 Port SHALL be: count  output  W  current packed BCD value, registered.
REQ-010 Port SHALL be: busy  output  1  high in RUN or PAUSED.
REQ-011 Port SHALL be: done  output  1  one-cycle terminal pulse, registered.
REQ-012 Port SHALL be: err  output  1  sticky invalid-load flag, registered.

Function
REQ-013 Controller SHALL have three states: IDLE, RUN, PAUSED.
REQ-014 Per-cycle priority SHALL be reset > load > pause > start > tick.
REQ-015 load in any state SHALL return FSM to IDLE and abort any countdown without a done pulse.
REQ-016 load with every load_val digit <= 9 SHALL set count = load_val and clear err on the next edge.
REQ-017 load with any digit > 9 SHALL leave count unchanged and set err = 1.
REQ-018 err SHALL hold until a valid load or reset.
REQ-019 start in IDLE with err = 0 and count != 0 SHALL enter RUN.
REQ-020 start in IDLE with err = 0 and count == 0 SHALL pulse done for one cycle and remain in IDLE.
REQ-021 start while err = 1 SHALL be ignored.
REQ-022 In RUN, tick SHALL decrement count by one in BCD; a count update is visible the cycle after the tick edge.
REQ-023 BCD decrement: a digit at 0 SHALL wrap to 9 and borrow into the next digit; digits above the borrow chain are unchanged.
REQ-024 A tick in RUN with count == 1 SHALL set count = 0, done = 1 for exactly one cycle, and FSM = IDLE, all on the same edge.
REQ-025 count SHALL never wrap below 0; the counter has no other terminal behaviour.
REQ-026 pause in RUN SHALL enter PAUSED; a tick in that same cycle SHALL be ignored.
REQ-027 In PAUSED, tick SHALL be ignored; start (without pause) SHALL return to RUN; pause held SHALL keep PAUSED.
REQ-028 tick, start, and pause SHALL have no effect on count in IDLE.
REQ-029 done SHALL be 0 in every cycle other than those named in REQ-020 and REQ-024.
REQ-030 busy SHALL be combinational from registered state: 1 iff state != IDLE.

Reset
REQ-031 reset SHALL set count = 0, state = IDLE, busy = 0, done = 0, err = 0 on the next edge, overriding all other inputs, including mid-RUN or mid-PAUSED.

Structure
REQ-032 Package bcd_countdown_pkg SHALL hold:
- FSM state typedef (IDLE, RUN, PAUSED);
- BCD_MAX = 4'd9;
- BCD_ZERO = 4'd0.
REQ-033 Sub-module bcd_digit_down SHALL implement one digit:
- inputs: digit, borrow_in;
- outputs: next digit, borrow_out;
- instantiated NUM_DIGITS times in a borrow chain.
REQ-034 BCD validity check and count-equals-one/zero detection SHALL live in bcd_countdown, not in the digit cell.

Verification
REQ-035 Load 8'h25, start, 25 ticks SHALL:
- produce count sequence 24, 23, ..., 20, 19, ..., 01, 00;
- pulse done once on the edge reaching 00;
- return busy to 0.
REQ-036 Borrow check:
- load 8'h10, start, one tick -> count 8'h09;
- load 8'h00, start -> done pulse next cycle, busy stays 0.
REQ-037 Invalid load: load 8'h3A after a valid 8'h42 SHALL:
- set err = 1 with count staying 8'h42;
- ignore a subsequent start;
- clear err on a following load 8'h05.
REQ-038 Pause/resume: load 8'h12, start, 3 ticks (count 8'h09), then pause with a simultaneous tick SHALL:
- hold count 8'h09 across 4 further ticks;
- resume the decrement after start.
REQ-039 Mid-operation overrides:
- reset asserted in RUN at count 8'h07 -> all outputs 0 next cycle, no done pulse;
- load 8'h33 asserted in RUN -> IDLE, count 8'h33, no done pulse.
